// File: rtl/if_id_buffer_if.sv
// ---------------------------------------------------------------------------
// if_id_buffer_if
//
// Purpose:
//   Bundles the fetch-side and decode-side signals of the IF/ID skid buffer
//   so the buffer, its neighbours and the testbench can pass one handle
//   around instead of a long port list.
//
// Signals:
//   inValid     fetch -> buffer   fetch stage offers an instruction
//   inReady     buffer -> fetch   buffer accepts an instruction this cycle
//   inInstr     fetch -> buffer   fetched instruction word (32)
//   inPC        fetch -> buffer   address of inInstr (32)
//   flush       ctrl  -> buffer   discard all buffered entries
//   outValid    buffer -> decode  head entry valid
//   outReady    decode -> buffer  decode consumes the head entry
//   outInstr    buffer -> decode  head instruction (32)
//   outPC       buffer -> decode  head PC (32)
//   outPCPlus4  buffer -> decode  outPC + 4 (32)
//   count       buffer -> any     number of buffered entries, 0..2
//   immSrc      buffer -> decode  immediate format select (IF_ID_IMMSRC_EN only)
//
// Modports:
//   slave  - the buffer's view (drives the buffer outputs)
//   master - the surrounding pipeline / testbench view
//
// Configuration macro: IF_ID_IMMSRC_EN adds the immSrc signal.
// ---------------------------------------------------------------------------
interface if_id_buffer_if;
    logic        inValid;
    logic        inReady;
    logic [31:0] inInstr;
    logic [31:0] inPC;
    logic        flush;
    logic        outValid;
    logic        outReady;
    logic [31:0] outInstr;
    logic [31:0] outPC;
    logic [31:0] outPCPlus4;
    logic [1:0]  count;
`ifdef IF_ID_IMMSRC_EN
    logic [1:0]  immSrc;
`endif

    modport slave (
        input  inValid,
        input  inInstr,
        input  inPC,
        input  flush,
        input  outReady,
        output inReady,
        output outValid,
        output outInstr,
        output outPC,
        output outPCPlus4,
`ifdef IF_ID_IMMSRC_EN
        output immSrc,
`endif
        output count
    );

    modport master (
        output inValid,
        output inInstr,
        output inPC,
        output flush,
        output outReady,
        input  inReady,
        input  outValid,
        input  outInstr,
        input  outPC,
        input  outPCPlus4,
`ifdef IF_ID_IMMSRC_EN
        input  immSrc,
`endif
        input  count
    );
endinterface

// File: rtl/if_id_buffer.sv
// ---------------------------------------------------------------------------
// if_id_buffer
//
// Purpose:
//   Two-entry FIFO between instruction fetch and decode. Fetch pushes
//   {instruction, PC} pairs with a valid/ready handshake; decode pops the
//   head entry the same way. A flush (taken branch/jump) empties the buffer.
//   While the buffer is empty the decode side sees a NOP at PC 0, so the
//   downstream decoder always has a harmless instruction to chew on.
//
// Parameters:
//   NOP_INSTR   instruction presented on outInstr while empty (addi x0,x0,0)
//
// Ports:
//   clk         single clock, all state changes on the rising edge
//   reset       synchronous, active-high; wins over flush, push and pop
//   bus         if_id_buffer_if.slave - fetch/decode handshake, data,
//               flush, count and (optionally) immSrc
//
// Configuration macro:
//   IF_ID_IMMSRC_EN  when defined, decodes immSrc from the head opcode:
//                    store -> 01, branch -> 10, jal -> 11, else -> 00.
//                    When undefined the immSrc signal does not exist.
// ---------------------------------------------------------------------------
module if_id_buffer #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            reset,
    if_id_buffer_if.slave   bus
);

    // Occupancy state. The encoding matches the entry count so the count
    // output is a trivial decode, but the decode is kept explicit anyway.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e      state_q,     state_d;
    logic [31:0] headInstr_q, headInstr_d;
    logic [31:0] headPC_q,    headPC_d;
    logic [31:0] tailInstr_q, tailInstr_d;
    logic [31:0] tailPC_q,    tailPC_d;

    logic        inReadyInt;
    logic        outValidInt;
    logic        pushEn;
    logic        popEn;

    // Handshake qualifiers. inReady deliberately ignores outReady so the
    // fetch side never sees a combinational path from decode back-pressure.
    always_comb begin
        inReadyInt  = !reset && (state_q != FULL);
        outValidInt = (state_q != EMPTY);
        pushEn      = bus.inValid && inReadyInt;
        popEn       = outValidInt && bus.outReady;
    end

    // Next-state and next-data logic. The head register always holds the
    // entry decode sees; the tail register only matters in FULL. Flush
    // overrides any push or pop happening in the same cycle.
    always_comb begin
        state_d     = state_q;
        headInstr_d = headInstr_q;
        headPC_d    = headPC_q;
        tailInstr_d = tailInstr_q;
        tailPC_d    = tailPC_q;

        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (pushEn) begin
                        state_d     = ONE;
                        headInstr_d = bus.inInstr;
                        headPC_d    = bus.inPC;
                    end
                end
                ONE: begin
                    if (pushEn && popEn) begin
                        // Head leaves and the newcomer takes its place.
                        state_d     = ONE;
                        headInstr_d = bus.inInstr;
                        headPC_d    = bus.inPC;
                    end else if (pushEn) begin
                        state_d     = FULL;
                        tailInstr_d = bus.inInstr;
                        tailPC_d    = bus.inPC;
                    end else if (popEn) begin
                        state_d     = EMPTY;
                    end
                end
                FULL: begin
                    // No push is possible here because inReady is low.
                    if (popEn) begin
                        state_d     = ONE;
                        headInstr_d = tailInstr_q;
                        headPC_d    = tailPC_q;
                    end
                end
                default: begin
                    state_d = EMPTY;
                end
            endcase
        end
    end

    // State and data registers. Reset clears the data too so stale entries
    // can never leak out, even though the outputs are gated by state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= EMPTY;
            headInstr_q <= '0;
            headPC_q    <= '0;
            tailInstr_q <= '0;
            tailPC_q    <= '0;
        end else begin
            state_q     <= state_d;
            headInstr_q <= headInstr_d;
            headPC_q    <= headPC_d;
            tailInstr_q <= tailInstr_d;
            tailPC_q    <= tailPC_d;
        end
    end

    // Decode-side outputs. An empty buffer presents a NOP at PC 0; the
    // PC+4 adder wraps naturally at the top of the address space.
    always_comb begin
        bus.inReady    = inReadyInt;
        bus.outValid   = outValidInt;
        bus.outInstr   = outValidInt ? headInstr_q : NOP_INSTR;
        bus.outPC      = outValidInt ? headPC_q    : 32'h0;
        bus.outPCPlus4 = bus.outPC + 32'd4;
        unique case (state_q)
            EMPTY:   bus.count = 2'd0;
            ONE:     bus.count = 2'd1;
            FULL:    bus.count = 2'd2;
            default: bus.count = 2'd0;
        endcase
    end

`ifdef IF_ID_IMMSRC_EN
    // Immediate format select straight from the presented opcode, so it
    // lines up with outInstr in the same cycle. The empty-buffer NOP is an
    // OP-IMM and therefore falls into the I-format default.
    always_comb begin
        unique case (bus.outInstr[6:0])
            7'b0100011: bus.immSrc = 2'b01;
            7'b1100011: bus.immSrc = 2'b10;
            7'b1101111: bus.immSrc = 2'b11;
            default:    bus.immSrc = 2'b00;
        endcase
    end
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// ---------------------------------------------------------------------------
// tb_if_id_buffer
//
// Purpose:
//   Directed self-checking bench for if_id_buffer. A queue of {instr, PC}
//   pairs models the FIFO contents: entries are pushed when the bench drives
//   an accepted instruction and popped when decode consumes the head, and
//   every cycle the DUT outputs are compared with the queue head.
//
// Configuration macro: IF_ID_IMMSRC_EN also checks immSrc.
// ---------------------------------------------------------------------------
module tb_if_id_buffer;

    localparam logic [31:0] NOP = 32'h00000013;

    logic clk;
    logic reset;

    if_id_buffer_if bus ();

    if_id_buffer #(
        .NOP_INSTR (NOP)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] expQ[$];
    int          testsRun  = 0;
    int          failCount = 0;

    // Immediate format the extender should receive for a given opcode.
    function automatic logic [1:0] expImm(input logic [31:0] instr);
        logic [1:0] r;
        case (instr[6:0])
            7'b0100011: r = 2'b01;
            7'b1100011: r = 2'b10;
            7'b1101111: r = 2'b11;
            default:    r = 2'b00;
        endcase
        return r;
    endfunction

    // One comparison: counts it and reports a mismatch with its tag.
    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compares every decode-side output against the head of the model queue.
    task automatic checkOutput(input string tag);
        logic [31:0] eInstr;
        logic [31:0] ePC;
        eInstr = (expQ.size() != 0) ? expQ[0][63:32] : NOP;
        ePC    = (expQ.size() != 0) ? expQ[0][31:0]  : 32'h0;
        checkEq({tag, ".outValid"},   {31'b0, bus.outValid}, {31'b0, expQ.size() != 0});
        checkEq({tag, ".count"},      {30'b0, bus.count},    32'(expQ.size()));
        checkEq({tag, ".outInstr"},   bus.outInstr,          eInstr);
        checkEq({tag, ".outPC"},      bus.outPC,             ePC);
        checkEq({tag, ".outPCPlus4"}, bus.outPCPlus4,        ePC + 32'd4);
`ifdef IF_ID_IMMSRC_EN
        checkEq({tag, ".immSrc"},     {30'b0, bus.immSrc},   {30'b0, expImm(eInstr)});
`endif
    endtask

    // Drives one cycle of inputs, checks inReady before the edge, updates
    // the model queue with what should have been accepted/consumed, and
    // checks the outputs just after the edge.
    task automatic applyStimulus(input string tag, input logic rst, input logic v,
                                 input logic [31:0] instr, input logic [31:0] pc,
                                 input logic oRdy, input logic fl);
        logic expReady;
        logic doPush;
        logic doPop;
        reset        = rst;
        bus.inValid  = v;
        bus.inInstr  = instr;
        bus.inPC     = pc;
        bus.outReady = oRdy;
        bus.flush    = fl;
        #1;
        expReady = !rst && (expQ.size() < 2);
        checkEq({tag, ".inReady"}, {31'b0, bus.inReady}, {31'b0, expReady});
        doPush = v && expReady;
        doPop  = (expQ.size() != 0) && oRdy;
        @(posedge clk);
        #1;
        if (rst || fl) begin
            expQ.delete();
        end else begin
            if (doPop)  expQ.delete(0);
            if (doPush) expQ.push_back({instr, pc});
        end
        checkOutput(tag);
    endtask

    initial begin
        reset        = 1'b1;
        bus.inValid  = 1'b0;
        bus.inInstr  = '0;
        bus.inPC     = '0;
        bus.outReady = 1'b0;
        bus.flush    = 1'b0;

        // Reset and idle state.
        applyStimulus("rst0", 1, 0, 32'h0, 32'h0, 0, 0);
        applyStimulus("rst1", 1, 1, 32'hDEADBEEF, 32'h100, 1, 0);
        applyStimulus("idle", 0, 0, 32'h0, 32'h0, 0, 0);
        checkEq("idle.plus4", bus.outPCPlus4, 32'h4);

        // First push visible one cycle later.
        applyStimulus("push1", 0, 1, 32'h00500093, 32'h0, 0, 0);
        checkEq("push1.plus4", bus.outPCPlus4, 32'h4);
        applyStimulus("pop1", 0, 0, 32'h0, 32'h0, 1, 0);

        // outReady and input data are ignored when nothing is valid.
        applyStimulus("ignore", 0, 0, 32'h12345678, 32'h40, 1, 0);

        // Three back-to-back pushes; the third must be refused.
        applyStimulus("fill0", 0, 1, 32'h00100093, 32'h0, 0, 0);
        applyStimulus("fill4", 0, 1, 32'h00200113, 32'h4, 0, 0);
        applyStimulus("fill8", 0, 1, 32'h00300193, 32'h8, 0, 0);
        checkEq("full.count", {30'b0, bus.count}, 32'd2);
        applyStimulus("stall", 0, 0, 32'h0, 32'h0, 0, 0);
        applyStimulus("drainA", 0, 0, 32'h0, 32'h0, 1, 0);
        checkEq("drainA.pc", bus.outPC, 32'h4);
        applyStimulus("drainB", 0, 0, 32'h0, 32'h0, 1, 0);

        // Simultaneous push and pop in ONE replaces the head.
        applyStimulus("one10", 0, 1, 32'h00112023, 32'h10, 0, 0);
        applyStimulus("swap14", 0, 1, 32'h0000006F, 32'h14, 1, 0);
        checkEq("swap14.pc", bus.outPC, 32'h14);

        // Flush in FULL beats a concurrent push and pop.
        applyStimulus("full18", 0, 1, 32'h00000063, 32'h18, 0, 0);
        applyStimulus("flush", 0, 1, 32'h00400213, 32'h1C, 1, 1);
        checkEq("flush.instr", bus.outInstr, 32'h00000013);

        // PC+4 wraps at the top of the address space.
        applyStimulus("wrap", 0, 1, 32'hFE000EE3, 32'hFFFFFFFC, 0, 0);
        checkEq("wrap.plus4", bus.outPCPlus4, 32'h0);
`ifdef IF_ID_IMMSRC_EN
        checkEq("wrap.immSrc", {30'b0, bus.immSrc}, 32'd2);
`endif

        // Reset mid-operation in FULL discards everything.
        applyStimulus("preRst", 0, 1, 32'h00500293, 32'h20, 0, 0);
        applyStimulus("midRst", 1, 1, 32'h00600313, 32'h24, 1, 0);
        checkEq("midRst.count", {30'b0, bus.count}, 32'd0);
        applyStimulus("postRst", 0, 0, 32'h0, 32'h0, 0, 0);
        applyStimulus("postRst2", 0, 0, 32'h0, 32'h0, 1, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
